// File: rtl/conv3x3_pipe_if.sv
// conv3x3_pipe_if: window-in / pixel-out stream bundle for conv3x3_pipe.
// master = producer/consumer side (host), slave = the filter.
//   inputData   9 pixels, row-major, pixel i at [i*PIXEL_W +: PIXEL_W]
//   inputValid  / inputReady   input beat handshake
//   modeSel     filter mode tagged onto each accepted beat
//   outputData  / outputValid / outputReady  output pixel handshake
interface conv3x3_pipe_if #(
    parameter int PIXEL_W = 8
);
    logic [9*PIXEL_W-1:0] inputData;
    logic                 inputValid;
    logic                 inputReady;
    logic [2:0]           modeSel;
    logic [PIXEL_W-1:0]   outputData;
    logic                 outputValid;
    logic                 outputReady;

    modport master (
        output inputData, inputValid, modeSel, outputReady,
        input  inputReady, outputData, outputValid
    );

    modport slave (
        input  inputData, inputValid, modeSel, outputReady,
        output inputReady, outputData, outputValid
    );
endinterface

// File: rtl/conv3x3_pipe.sv
// conv3x3_pipe: pipelined 3x3 convolution, fixed and user kernels.
// Ports: clk, rst_n (sync, active-low); bus (stream if, slave);
//   coefWe/coefAddr/coefData: user kernel load (addr 9 = shift);
//   satCount: saturated-pixel counter, satClear clears it.
module conv3x3_pipe #(
    parameter int PIXEL_W    = 8,
    parameter int COEF_W     = 8,
    parameter int BRIGHTNESS = 0,
    parameter int THRESHOLD  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    conv3x3_pipe_if.slave            bus,
    input  logic                     coefWe,
    input  logic [3:0]               coefAddr,
    input  logic signed [COEF_W-1:0] coefData,
    output logic [15:0]              satCount,
    input  logic                     satClear
);
    localparam int PROD_W = PIXEL_W + 1 + COEF_W;
    localparam int SUM_W  = PIXEL_W + COEF_W + 5;
    localparam int V_W    = SUM_W + 2;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    localparam logic signed [V_W-1:0] MAXV = V_W'((1 << PIXEL_W) - 1);

    function automatic sum_t sx(input prod_t v);
        return sum_t'(v);
    endfunction

    logic en;
    assign en = bus.outputReady | ~bus.outputValid;
    assign bus.inputReady = en;

    // user kernel
    coef_t      ucoef [9];
    logic [3:0] ushift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++)
                ucoef[i] <= (i == 4) ? coef_t'(1) : coef_t'(0);
            ushift <= 4'd0;
        end else if (coefWe) begin
            if (coefAddr < 4'd9)
                ucoef[coefAddr] <= coefData;
            else if (coefAddr == 4'd9)
                ushift <= coefData[3:0];
        end
    end

    // kernel select for the beat at the input
    coef_t      kern [9];
    logic [3:0] ksh;

    always_comb begin
        for (int i = 0; i < 9; i++)
            kern[i] = (i == 4) ? coef_t'(1) : coef_t'(0);
        ksh = 4'd0;
        unique case (bus.modeSel)
            3'd1: begin
                for (int i = 0; i < 9; i++)
                    kern[i] = (i == 4) ? coef_t'(4) :
                              (i % 2 == 1) ? coef_t'(2) : coef_t'(1);
                ksh = 4'd4;
            end
            3'd2: begin
                for (int i = 0; i < 9; i++)
                    kern[i] = (i == 4) ? coef_t'(5) :
                              (i % 2 == 1) ? coef_t'(-1) : coef_t'(0);
            end
            3'd3: begin
                for (int i = 0; i < 9; i++)
                    kern[i] = (i == 4) ? coef_t'(8) : coef_t'(-1);
            end
            3'd4: begin
                for (int i = 0; i < 9; i++)
                    kern[i] = ucoef[i];
                ksh = ushift;
            end
            default: ;
        endcase
    end

    prod_t prod [9];

    always_comb begin
        for (int i = 0; i < 9; i++)
            prod[i] = prod_t'($signed({1'b0, bus.inputData[i*PIXEL_W +: PIXEL_W]}))
                    * prod_t'(kern[i]);
    end

    // S1 products, then the adder tree split across two registers
    // (row sums, total) so a beat is visible after edge k+3.
    prod_t      p_q   [9];
    sum_t       row_q [3];
    sum_t       sum_q;
    logic [2:0] m1_q, m2_q, m3_q;
    logic [3:0] sh1_q, sh2_q, sh3_q;
    logic       v1_q, v2_q, v3_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 9; i++)
                p_q[i] <= prod[i];
            m1_q  <= bus.modeSel;
            sh1_q <= ksh;
            for (int j = 0; j < 3; j++)
                row_q[j] <= sx(p_q[3*j]) + sx(p_q[3*j+1]) + sx(p_q[3*j+2]);
            m2_q  <= m1_q;
            sh2_q <= sh1_q;
            sum_q <= row_q[0] + row_q[1] + row_q[2];
            m3_q  <= m2_q;
            sh3_q <= sh2_q;
        end
    end

    // normalise / threshold / clamp
    sum_t                  shd;
    logic signed [V_W-1:0] val;
    logic [PIXEL_W-1:0]    pix_n;
    logic                  sat_n;

    always_comb begin
        shd   = sum_q >>> sh3_q;
        val   = V_W'(shd) + V_W'(BRIGHTNESS);
        pix_n = '0;
        sat_n = 1'b0;
        if (m3_q == 3'd3) begin
            if (sum_q > sum_t'(THRESHOLD))
                pix_n = '1;
        end else if (val[V_W-1]) begin
            sat_n = 1'b1;
        end else if (val > MAXV) begin
            pix_n = '1;
            sat_n = 1'b1;
        end else begin
            pix_n = val[PIXEL_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q            <= 1'b0;
            v2_q            <= 1'b0;
            v3_q            <= 1'b0;
            bus.outputValid <= 1'b0;
            bus.outputData  <= '0;
        end else if (en) begin
            v1_q            <= bus.inputValid;
            v2_q            <= v1_q;
            v3_q            <= v2_q;
            bus.outputValid <= v3_q;
            if (v3_q)
                bus.outputData <= pix_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            satCount <= 16'd0;
        else if (satClear)
            satCount <= 16'd0;
        else if (en && v3_q && sat_n && satCount != 16'hFFFF)
            satCount <= satCount + 16'd1;
    end
endmodule
